// File: rtl/tl_mon_pkg.sv
// rtl/tl_mon_pkg.sv - shared opcodes, error indices, beat FSM state and helpers for the TileLink tracker
package tl_mon_pkg;

  localparam logic [2:0] A_PUT_FULL      = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
  localparam logic [2:0] A_ARITHMETIC    = 3'd2;
  localparam logic [2:0] A_LOGICAL       = 3'd3;
  localparam logic [2:0] A_GET           = 3'd4;
  localparam logic [2:0] A_INTENT        = 3'd5;
  localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] A_ACQUIRE_PERM  = 3'd7;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  localparam int ERR_A_DUP_SRC  = 0;
  localparam int ERR_D_NO_SRC   = 1;
  localparam int ERR_A_BURST    = 2;
  localparam int ERR_D_BURST    = 3;
  localparam int ERR_E_NO_SINK  = 4;
  localparam int ERR_D_DUP_SINK = 5;
  localparam int ERR_A_UNSTABLE = 6;
  localparam int ERR_D_UNSTABLE = 7;

  // Wide enough for a 2^15-byte message on an 8-bit bus.
  localparam int BEAT_W = 16;

  typedef enum logic {
    BEAT_IDLE  = 1'b0,
    BEAT_BURST = 1'b1
  } beat_state_e;

  function automatic logic is_a_data(input logic [2:0] op);
    return (op <= A_LOGICAL);
  endfunction

  function automatic logic is_d_data(input logic [2:0] op);
    return (op == D_ACCESS_ACK_DATA) || (op == D_GRANT_DATA);
  endfunction

  function automatic logic [BEAT_W-1:0] beats(input logic [3:0] size,
                                              input logic       has_data,
                                              input logic [3:0] lg_bytes);
    logic [BEAT_W-1:0] n;
    n = BEAT_W'(1);
    if (has_data && (size > lg_bytes)) n = BEAT_W'(1) << (size - lg_bytes);
    return n;
  endfunction

  function automatic logic [2:0] first_err_code(input logic [7:0] errs);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (errs[i]) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/tl_beat_fsm.sv
// rtl/tl_beat_fsm.sv - per-channel beat tracker: flags first/last beats and header changes inside a burst
module tl_beat_fsm
  import tl_mon_pkg::*;
#(
  parameter int SOURCE_W = 4,
  parameter int LG_BYTES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_fire,
  input  logic [2:0]          i_opcode,
  input  logic [3:0]          i_size,
  input  logic [SOURCE_W-1:0] i_source,
  input  logic                i_has_data,
  output logic                o_first,
  output logic                o_last,
  output logic                o_burst_err
);

  beat_state_e         r_state;
  beat_state_e         w_state_nxt;
  logic [2:0]          r_opcode;
  logic [3:0]          r_size;
  logic [SOURCE_W-1:0] r_source;
  logic [BEAT_W-1:0]   r_rem;
  logic [BEAT_W-1:0]   w_rem_nxt;
  logic [BEAT_W-1:0]   w_beats;
  logic                w_latch;

  assign w_beats = beats(i_size, i_has_data, 4'(LG_BYTES));

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_latch     = 1'b0;
    o_first     = 1'b0;
    o_last      = 1'b0;
    o_burst_err = 1'b0;
    case (r_state)
      BEAT_IDLE: begin
        if (i_fire) begin
          o_first = 1'b1;
          if (w_beats == BEAT_W'(1)) begin
            o_last = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_rem_nxt   = w_beats - BEAT_W'(1);
            w_state_nxt = BEAT_BURST;
          end
        end
      end
      BEAT_BURST: begin
        if (i_fire) begin
          // A mismatching beat is still consumed so the burst stays aligned.
          o_burst_err = (i_opcode != r_opcode) || (i_size != r_size) ||
                        (i_source != r_source);
          w_rem_nxt   = r_rem - BEAT_W'(1);
          if (r_rem == BEAT_W'(1)) begin
            o_last      = 1'b1;
            w_state_nxt = BEAT_IDLE;
          end
        end
      end
      default: w_state_nxt = BEAT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= BEAT_IDLE;
      r_rem    <= '0;
      r_opcode <= '0;
      r_size   <= '0;
      r_source <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_latch) begin
        r_opcode <= i_opcode;
        r_size   <= i_size;
        r_source <= i_source;
      end
    end
  end

endmodule

// File: rtl/tl_txn_tracker.sv
// rtl/tl_txn_tracker.sv - TileLink A/D/E transaction tracker: outstanding sources, pending GrantAcks,
// sticky protocol error flags and completed-message counters
module tl_txn_tracker
  import tl_mon_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 4,
  parameter int SINK_W   = 4,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_param,
  input  logic [3:0]             a_size,
  input  logic [SOURCE_W-1:0]    a_source,
  input  logic [ADDR_W-1:0]      a_address,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [3:0]             d_size,
  input  logic [SOURCE_W-1:0]    d_source,
  input  logic [SINK_W-1:0]      d_sink,
  input  logic                   d_denied,
  input  logic                   e_valid,
  input  logic                   e_ready,
  input  logic [SINK_W-1:0]      e_sink,
  output logic [(1<<SOURCE_W)-1:0] src_busy,
  output logic [(1<<SINK_W)-1:0]   sink_busy,
  output logic [7:0]             err_flags,
  output logic [3:0]             err_first,
  output logic [CNT_W-1:0]       a_msg_cnt,
  output logic [CNT_W-1:0]       d_msg_cnt
);

  localparam int NSRC     = 1 << SOURCE_W;
  localparam int NSINK    = 1 << SINK_W;
  localparam int LG_BYTES = $clog2(DATA_W / 8);
  localparam int A_PL_W   = 3 + 3 + 4 + SOURCE_W + ADDR_W;
  localparam int D_PL_W   = 3 + 4 + SOURCE_W + SINK_W + 1;

  logic w_a_fire, w_d_fire, w_e_fire;
  logic w_a_first, w_a_last, w_a_burst_err;
  logic w_d_first, w_d_last, w_d_burst_err;
  logic w_d_clr_src, w_d_set_sink;

  logic [NSRC-1:0]   r_src_busy, w_src_set, w_src_clr;
  logic [NSINK-1:0]  r_sink_busy, w_sink_set, w_sink_clr;
  logic [7:0]        r_err_flags, w_err_new;
  logic [3:0]        r_err_first;
  logic [CNT_W-1:0]  r_a_cnt, r_d_cnt;

  logic              r_a_hold, r_d_hold;
  logic [A_PL_W-1:0] r_a_payload, w_a_payload;
  logic [D_PL_W-1:0] r_d_payload, w_d_payload;

  assign w_a_fire = a_valid & a_ready;
  assign w_d_fire = d_valid & d_ready;
  assign w_e_fire = e_valid & e_ready;

  tl_beat_fsm #(.SOURCE_W(SOURCE_W), .LG_BYTES(LG_BYTES)) u_a_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_fire      (w_a_fire),
    .i_opcode    (a_opcode),
    .i_size      (a_size),
    .i_source    (a_source),
    .i_has_data  (is_a_data(a_opcode)),
    .o_first     (w_a_first),
    .o_last      (w_a_last),
    .o_burst_err (w_a_burst_err)
  );

  tl_beat_fsm #(.SOURCE_W(SOURCE_W), .LG_BYTES(LG_BYTES)) u_d_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_fire      (w_d_fire),
    .i_opcode    (d_opcode),
    .i_size      (d_size),
    .i_source    (d_source),
    .i_has_data  (is_d_data(d_opcode)),
    .o_first     (w_d_first),
    .o_last      (w_d_last),
    .o_burst_err (w_d_burst_err)
  );

  // ReleaseAck answers a C-channel Release, so it never retires an A source.
  assign w_d_clr_src  = w_d_last && ((d_opcode == D_ACCESS_ACK) || (d_opcode == D_ACCESS_ACK_DATA) ||
                                     (d_opcode == D_HINT_ACK) || (d_opcode == D_GRANT) ||
                                     (d_opcode == D_GRANT_DATA));
  assign w_d_set_sink = w_d_last && !d_denied &&
                        ((d_opcode == D_GRANT) || (d_opcode == D_GRANT_DATA));

  assign w_src_set  = w_a_first    ? (NSRC'(1) << a_source)  : '0;
  assign w_src_clr  = w_d_clr_src  ? (NSRC'(1) << d_source)  : '0;
  assign w_sink_set = w_d_set_sink ? (NSINK'(1) << d_sink)   : '0;
  assign w_sink_clr = w_e_fire     ? (NSINK'(1) << e_sink)   : '0;

  assign w_a_payload = {a_opcode, a_param, a_size, a_source, a_address};
  assign w_d_payload = {d_opcode, d_size, d_source, d_sink, d_denied};

  always_comb begin
    w_err_new = '0;
    w_err_new[ERR_A_DUP_SRC]  = w_a_first && r_src_busy[a_source] &&
                                !(w_d_clr_src && (d_source == a_source));
    w_err_new[ERR_D_NO_SRC]   = w_d_clr_src && !r_src_busy[d_source];
    w_err_new[ERR_A_BURST]    = w_a_burst_err;
    w_err_new[ERR_D_BURST]    = w_d_burst_err;
    w_err_new[ERR_E_NO_SINK]  = w_e_fire && !r_sink_busy[e_sink];
    w_err_new[ERR_D_DUP_SINK] = w_d_set_sink && r_sink_busy[d_sink];
    w_err_new[ERR_A_UNSTABLE] = r_a_hold && (!a_valid || (w_a_payload != r_a_payload));
    w_err_new[ERR_D_UNSTABLE] = r_d_hold && (!d_valid || (w_d_payload != r_d_payload));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_busy  <= '0;
      r_sink_busy <= '0;
      r_err_flags <= '0;
      r_err_first <= '0;
      r_a_cnt     <= '0;
      r_d_cnt     <= '0;
      r_a_hold    <= 1'b0;
      r_d_hold    <= 1'b0;
      r_a_payload <= '0;
      r_d_payload <= '0;
    end else begin
      // Set wins over a same-cycle clear of the same bit.
      r_src_busy  <= (r_src_busy & ~w_src_clr) | w_src_set;
      r_sink_busy <= (r_sink_busy & ~w_sink_clr) | w_sink_set;
      if (clr) begin
        r_err_flags <= '0;
        r_err_first <= '0;
      end else begin
        r_err_flags <= r_err_flags | w_err_new;
        if (!r_err_first[3] && (w_err_new != 8'd0))
          r_err_first <= {1'b1, first_err_code(w_err_new)};
      end
      if (w_a_last && (r_a_cnt != '1)) r_a_cnt <= r_a_cnt + CNT_W'(1);
      if (w_d_last && (r_d_cnt != '1)) r_d_cnt <= r_d_cnt + CNT_W'(1);
      r_a_hold    <= a_valid & ~a_ready;
      r_d_hold    <= d_valid & ~d_ready;
      r_a_payload <= w_a_payload;
      r_d_payload <= w_d_payload;
    end
  end

  assign src_busy  = r_src_busy;
  assign sink_busy = r_sink_busy;
  assign err_flags = r_err_flags;
  assign err_first = r_err_first;
  assign a_msg_cnt = r_a_cnt;
  assign d_msg_cnt = r_d_cnt;

endmodule

// File: tb/tb_tl_txn_tracker.sv
// tb/tb_tl_txn_tracker.sv - directed and randomized bench for tl_txn_tracker with a message-level reference model
module tb_tl_txn_tracker;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int SOURCE_W = 4;
  localparam int SINK_W   = 4;
  localparam int CNT_W    = 6;
  localparam int NSRC     = 16;
  localparam int NSINK    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr;
  logic a_valid, a_ready, d_valid, d_ready, e_valid, e_ready, d_denied;
  logic [2:0] a_opcode, a_param, d_opcode;
  logic [3:0] a_size, d_size;
  logic [SOURCE_W-1:0] a_source, d_source;
  logic [SINK_W-1:0] d_sink, e_sink;
  logic [ADDR_W-1:0] a_address;
  wire [NSRC-1:0] src_busy;
  wire [NSINK-1:0] sink_busy;
  wire [7:0] err_flags;
  wire [3:0] err_first;
  wire [CNT_W-1:0] a_msg_cnt, d_msg_cnt;

  tl_txn_tracker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SOURCE_W(SOURCE_W),
                   .SINK_W(SINK_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink),
    .src_busy(src_busy), .sink_busy(sink_busy), .err_flags(err_flags),
    .err_first(err_first), .a_msg_cnt(a_msg_cnt), .d_msg_cnt(d_msg_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: beats left in the current message per channel, plus its header.
  int ma_left, md_left, ma_op, ma_sz, ma_src, md_op, md_sz, md_src;
  bit m_src [NSRC];
  bit m_sink [NSINK];
  logic [7:0] m_flags;
  logic [3:0] m_first;
  int m_acnt, m_dcnt;
  bit pa_hold, pd_hold;
  logic [2:0] pa_op, pa_param, pd_op;
  logic [3:0] pa_sz, pa_src, pd_sz, pd_src, pd_sink;
  logic [63:0] pa_addr;
  logic pd_den;

  function automatic int msg_beats(input int size, input bit has_data);
    if (has_data && size > 3) return 2 ** (size - 3);
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ma_left = 0; md_left = 0;
    ma_op = 0; ma_sz = 0; ma_src = 0; md_op = 0; md_sz = 0; md_src = 0;
    for (int i = 0; i < NSRC; i++) m_src[i] = 0;
    for (int i = 0; i < NSINK; i++) m_sink[i] = 0;
    m_flags = 0; m_first = 0; m_acnt = 0; m_dcnt = 0;
    pa_hold = 0; pd_hold = 0;
  endtask

  task automatic model_step();
    logic [7:0] e;
    bit a_first, a_last, d_last, d_frees, d_grants;
    int n;
    e = 0; a_first = 0; a_last = 0; d_last = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (a_valid && a_ready) begin
      if (ma_left == 0) begin
        a_first = 1;
        n = msg_beats(int'(a_size), a_opcode <= 3);
        if (n == 1) a_last = 1;
        else begin
          ma_left = n - 1; ma_op = int'(a_opcode); ma_sz = int'(a_size); ma_src = int'(a_source);
        end
      end else begin
        if (int'(a_opcode) != ma_op || int'(a_size) != ma_sz || int'(a_source) != ma_src) e[2] = 1;
        ma_left--;
        if (ma_left == 0) a_last = 1;
      end
    end
    if (d_valid && d_ready) begin
      if (md_left == 0) begin
        n = msg_beats(int'(d_size), d_opcode == 1 || d_opcode == 5);
        if (n == 1) d_last = 1;
        else begin
          md_left = n - 1; md_op = int'(d_opcode); md_sz = int'(d_size); md_src = int'(d_source);
        end
      end else begin
        if (int'(d_opcode) != md_op || int'(d_size) != md_sz || int'(d_source) != md_src) e[3] = 1;
        md_left--;
        if (md_left == 0) d_last = 1;
      end
    end
    d_frees  = d_last && (d_opcode inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    d_grants = d_last && (d_opcode inside {3'd4, 3'd5}) && !d_denied;
    if (a_first && m_src[a_source] && !(d_frees && d_source == a_source)) e[0] = 1;
    if (d_frees && !m_src[d_source]) e[1] = 1;
    if (e_valid && e_ready && !m_sink[e_sink]) e[4] = 1;
    if (d_grants && m_sink[d_sink]) e[5] = 1;
    if (pa_hold && (!a_valid || a_opcode != pa_op || a_param != pa_param || a_size != pa_sz ||
                    a_source != pa_src || a_address != pa_addr)) e[6] = 1;
    if (pd_hold && (!d_valid || d_opcode != pd_op || d_size != pd_sz || d_source != pd_src ||
                    d_sink != pd_sink || d_denied != pd_den)) e[7] = 1;
    if (d_frees) m_src[d_source] = 0;
    if (a_first) m_src[a_source] = 1;
    if (e_valid && e_ready) m_sink[e_sink] = 0;
    if (d_grants) m_sink[d_sink] = 1;
    if (clr) begin
      m_flags = 0; m_first = 0;
    end else begin
      if (!m_first[3] && e != 0) begin
        for (int i = 0; i < 8; i++) if (e[i]) begin m_first = {1'b1, 3'(i)}; break; end
      end
      m_flags = m_flags | e;
    end
    if (a_last && m_acnt < CNT_MAX) m_acnt++;
    if (d_last && m_dcnt < CNT_MAX) m_dcnt++;
    pa_hold = a_valid && !a_ready;
    pa_op = a_opcode; pa_param = a_param; pa_sz = a_size; pa_src = a_source; pa_addr = a_address;
    pd_hold = d_valid && !d_ready;
    pd_op = d_opcode; pd_sz = d_size; pd_src = d_source; pd_sink = d_sink; pd_den = d_denied;
  endtask

  task automatic compare_all();
    logic [NSRC-1:0] es;
    logic [NSINK-1:0] ek;
    for (int i = 0; i < NSRC; i++) es[i] = m_src[i];
    for (int i = 0; i < NSINK; i++) ek[i] = m_sink[i];
    chk("src_busy", src_busy, es);
    chk("sink_busy", sink_busy, ek);
    chk("err_flags", err_flags, m_flags);
    chk("err_first", err_first, m_first);
    chk("a_msg_cnt", a_msg_cnt, m_acnt);
    chk("d_msg_cnt", d_msg_cnt, m_dcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    rst = 0; clr = 0;
    a_valid = 0; a_ready = 1; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0; a_address = 0;
    d_valid = 0; d_ready = 1; d_opcode = 0; d_size = 0; d_source = 0; d_sink = 0; d_denied = 0;
    e_valid = 0; e_ready = 1; e_sink = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic a_send(input int op, input int size, input int src);
    int n;
    n = msg_beats(size, op <= 3);
    for (int b = 0; b < n; b++) begin
      a_valid = 1; a_ready = 1; a_opcode = 3'(op); a_size = 4'(size); a_source = 4'(src);
      a_address = 64'h1000; tick();
    end
    a_valid = 0;
  endtask

  task automatic d_send(input int op, input int size, input int src, input int sink, input int nb);
    for (int b = 0; b < nb; b++) begin
      d_valid = 1; d_ready = 1; d_opcode = 3'(op); d_size = 4'(size); d_source = 4'(src);
      d_sink = 4'(sink); d_denied = 0; tick();
    end
    d_valid = 0;
  endtask

  initial begin
    set_idle();
    model_reset();
    rst = 1; tick(); tick(); rst = 0;
    chk("reset_flags", err_flags, 8'h00);
    chk("reset_first", err_first, 4'h0);

    // Get then 8-beat AccessAckData
    a_send(4, 6, 3);
    chk("get_busy_set", src_busy[3], 1'b1);
    d_send(1, 6, 3, 0, 8);
    chk("get_busy_clr", src_busy[3], 1'b0);
    chk("get_dcnt", d_msg_cnt, 6'd1);
    chk("get_flags", err_flags, 8'h00);

    // Duplicate source
    do_reset();
    a_send(4, 6, 5);
    a_send(4, 6, 5);
    chk("dup_flags", err_flags, 8'h01);
    chk("dup_first", err_first, 4'b1000);

    // PutFullData burst with a source change on beat 4
    do_reset();
    for (int b = 0; b < 8; b++) begin
      a_valid = 1; a_opcode = 3'd0; a_size = 4'd6; a_source = (b == 3) ? 4'd6 : 4'd2;
      a_address = 64'h2000; tick();
    end
    a_valid = 0;
    chk("burst_flags", err_flags, 8'h04);
    chk("burst_first", err_first, 4'b1010);
    chk("burst_acnt", a_msg_cnt, 6'd1);

    // Acquire / GrantData / GrantAck
    do_reset();
    a_send(6, 6, 1);
    d_send(5, 6, 1, 2, 8);
    chk("grant_sink_set", sink_busy, 16'h0004);
    chk("grant_src_clr", src_busy, 16'h0000);
    e_valid = 1; e_sink = 4'd2; tick(); e_valid = 0;
    chk("grantack_sink_clr", sink_busy, 16'h0000);
    chk("grant_flags", err_flags, 8'h00);

    // Unstable A payload while stalled, then clr against a same-cycle error
    do_reset();
    a_valid = 1; a_ready = 0; a_opcode = 3'd4; a_address = 64'h100; tick();
    a_address = 64'h200; tick();
    chk("unstable_flag", err_flags[6], 1'b1);
    a_valid = 0; a_ready = 1; clr = 1; tick(); clr = 0;
    tick();
    chk("clr_flags", err_flags, 8'h00);
    chk("clr_first", err_first, 4'h0);

    // Reset in the middle of a D burst
    do_reset();
    d_send(1, 6, 0, 0, 3);
    do_reset();
    a_send(4, 0, 0);
    d_send(0, 0, 0, 0, 1);
    chk("midrst_dcnt", d_msg_cnt, 6'd1);
    chk("midrst_flags", err_flags, 8'h00);

    // Same-cycle set and clear of one source bit
    do_reset();
    a_send(4, 0, 7);
    a_valid = 1; a_opcode = 3'd4; a_size = 0; a_source = 4'd7;
    d_valid = 1; d_opcode = 3'd0; d_size = 0; d_source = 4'd7; tick();
    a_valid = 0; d_valid = 0;
    chk("setclr_busy", src_busy, 16'h0080);
    chk("setclr_flags", err_flags, 8'h00);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 70; i++) begin
      a_valid = 1; a_opcode = 3'd4; a_size = 0; a_source = 0;
      d_valid = 1; d_opcode = 3'd0; d_size = 0; d_source = 0; tick();
    end
    a_valid = 0; d_valid = 0;
    chk("sat_acnt", a_msg_cnt, 6'h3f);
    chk("sat_dcnt", d_msg_cnt, 6'h3f);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(399) == 0);
      clr = ($urandom_range(49) == 0);
      if (!(a_valid && !a_ready) || $urandom_range(9) == 0) begin
        a_valid = $urandom_range(1);
        a_param = 3'($urandom_range(7));
        a_address = {$urandom, $urandom};
        if ($urandom_range(3) == 0) begin
          a_opcode = 3'($urandom_range(7)); a_size = 4'($urandom_range(6));
          a_source = 4'($urandom_range(3));
        end
      end
      a_ready = ($urandom_range(3) != 0);
      if (!(d_valid && !d_ready) || $urandom_range(9) == 0) begin
        d_valid = $urandom_range(1);
        d_sink = 4'($urandom_range(3));
        d_denied = ($urandom_range(5) == 0);
        if ($urandom_range(3) == 0) begin
          d_opcode = 3'($urandom_range(7)); d_size = 4'($urandom_range(6));
          d_source = 4'($urandom_range(3));
        end
      end
      d_ready = ($urandom_range(3) != 0);
      e_valid = $urandom_range(1);
      e_ready = $urandom_range(1);
      e_sink = 4'($urandom_range(3));
      tick();
    end
    set_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
